// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared types and constants for the mem_bridge slave.
//   size_e        - access size encoding of data_size
//   port_state_e  - per-port handshake FSM states
//   *_OFS         - MMIO register offsets below 2^ADDR_W
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } port_state_e;

  localparam int HALT_OFS    = 8;
  localparam int CONSOLE_OFS = 4;
  localparam int PRINT_OFS   = 16;

endpackage

// File: rtl/mem_bridge_lane.sv
// mem_bridge_lane: combinational lane logic for the 64-bit data port.
//   word        in  current contents of the addressed 64-bit word
//   offset      in  address[2:0]
//   size        in  access size
//   is_unsigned in  1 = zero-extend loads
//   wdata       in  right-aligned store data
//   aligned     out access is naturally aligned for its size
//   load_val    out extracted and extended load value
//   store_word  out word with the store bytes merged in (read-modify-write)
module mem_bridge_lane
  import mem_bridge_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  offset,
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [63:0] wdata,
  output logic        aligned,
  output logic [63:0] load_val,
  output logic [63:0] store_word
);

  logic [2:0]  ofs;
  logic [5:0]  sh;
  logic [63:0] size_mask;
  logic [63:0] raw;
  logic [63:0] mask;

  always_comb begin
    aligned   = 1'b1;
    ofs       = offset;
    size_mask = '1;
    case (size)
      SZ_BYTE: size_mask = 64'hFF;
      SZ_HALF: begin
        size_mask = 64'hFFFF;
        ofs       = {offset[2:1], 1'b0};
        aligned   = ~offset[0];
      end
      SZ_WORD: begin
        size_mask = 64'hFFFF_FFFF;
        ofs       = {offset[2], 2'b00};
        aligned   = (offset[1:0] == 2'b00);
      end
      default: begin
        ofs     = 3'd0;
        aligned = (offset == 3'd0);
      end
    endcase

    sh  = {ofs, 3'b000};
    raw = (word >> sh) & size_mask;

    load_val = raw;
    if (!is_unsigned) begin
      case (size)
        SZ_BYTE: load_val = {{56{raw[7]}}, raw[7:0]};
        SZ_HALF: load_val = {{48{raw[15]}}, raw[15:0]};
        SZ_WORD: load_val = {{32{raw[31]}}, raw[31:0]};
        default: load_val = raw;
      endcase
    end

    mask       = size_mask << sh;
    store_word = (word & ~mask) | ((wdata << sh) & mask);
  end

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: single-clock memory/MMIO slave with a 32-bit fetch port and a
// 64-bit load/store port, each with its own IDLE/WAIT/RESP handshake FSM.
//   phi1, rst                 clock, async active-low reset
//   instruction_*             fetch port (level request, one-cycle valid)
//   data_*, input_data_*      load port; output_data_* store port
//   halt/console_*/print_*    MMIO bring-up outputs
//   err                       sticky: misaligned, out-of-range, load+store conflict
// Optional feature macro: MEM_BRIDGE_MMIO_EN enables the MMIO window at the
// top of the address space; without it those outputs are tied to 0.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int ADDR_W        = 56,
  parameter int DEPTH_WORDS   = 4096,
  parameter int INSTR_LATENCY = 0,
  parameter int DATA_LATENCY  = 1
) (
  input  logic              phi1,
  input  logic              rst,
  input  logic [ADDR_W-1:0] instruction_address,
  input  logic              input_instruction_request,
  output logic [31:0]       input_instruction,
  output logic              input_instruction_valid,
  input  logic [ADDR_W-1:0] data_address,
  input  logic [1:0]        data_size,
  input  logic              input_data_unsigned,
  input  logic              input_data_request,
  output logic [63:0]       input_data,
  output logic              input_data_valid,
  input  logic [63:0]       output_data,
  input  logic              output_data_request,
  output logic              output_data_complete,
  output logic              halt,
  output logic              console_valid,
  output logic [7:0]        console_char,
  output logic              print_valid,
  output logic [63:0]       print_value,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [63:0] mem [DEPTH_WORDS];

  // ---------------- fetch port ----------------
  port_state_e       i_state, i_state_nx;
  logic [15:0]       i_cnt, i_cnt_nx;
  logic              i_latch;
  logic [ADDR_W-1:0] i_addr_q;
  logic              i_in_range;
  logic [63:0]       i_word;

  always_comb begin
    i_state_nx = i_state;
    i_cnt_nx   = i_cnt;
    i_latch    = 1'b0;
    case (i_state)
      ST_IDLE: if (input_instruction_request) begin
        i_latch = 1'b1;
        if (INSTR_LATENCY == 0) i_state_nx = ST_RESP;
        else begin
          i_state_nx = ST_WAIT;
          i_cnt_nx   = 16'(INSTR_LATENCY);
        end
      end
      ST_WAIT: begin
        i_cnt_nx = i_cnt - 16'd1;
        if (i_cnt == 16'd1) i_state_nx = ST_RESP;
      end
      default: i_state_nx = ST_IDLE;
    endcase
  end

  assign i_in_range = (i_addr_q[ADDR_W-1:IDX_W+3] == '0);
  assign i_word     = mem[i_addr_q[IDX_W+2:3]];

  always_ff @(posedge phi1 or negedge rst) begin
    if (!rst) begin
      i_state                 <= ST_IDLE;
      i_cnt                   <= '0;
      i_addr_q                <= '0;
      input_instruction       <= '0;
      input_instruction_valid <= 1'b0;
    end else begin
      i_state                 <= i_state_nx;
      i_cnt                   <= i_cnt_nx;
      if (i_latch) i_addr_q   <= instruction_address;
      input_instruction_valid <= (i_state == ST_RESP);
      if (i_state == ST_RESP)
        input_instruction <= !i_in_range ? 32'd0 :
                             (i_addr_q[2] ? i_word[63:32] : i_word[31:0]);
    end
  end

  // ---------------- data port ----------------
  port_state_e       d_state, d_state_nx;
  logic [15:0]       d_cnt, d_cnt_nx;
  logic              d_latch, d_conflict;
  logic [ADDR_W-1:0] d_addr_q;
  size_e             d_size_q;
  logic              d_uns_q, d_store_q;
  logic [63:0]       d_wdata_q;
  logic [63:0]       d_word, lane_load, lane_store;
  logic              lane_aligned, d_in_range, d_mmio, d_bad;
  logic              d_resp;

  always_comb begin
    d_state_nx = d_state;
    d_cnt_nx   = d_cnt;
    d_latch    = 1'b0;
    d_conflict = 1'b0;
    case (d_state)
      ST_IDLE: if (output_data_request || input_data_request) begin
        d_latch    = 1'b1;
        d_conflict = output_data_request && input_data_request;
        if (DATA_LATENCY == 0) d_state_nx = ST_RESP;
        else begin
          d_state_nx = ST_WAIT;
          d_cnt_nx   = 16'(DATA_LATENCY);
        end
      end
      ST_WAIT: begin
        d_cnt_nx = d_cnt - 16'd1;
        if (d_cnt == 16'd1) d_state_nx = ST_RESP;
      end
      default: d_state_nx = ST_IDLE;
    endcase
  end

  assign d_resp     = (d_state == ST_RESP);
  assign d_word     = mem[d_addr_q[IDX_W+2:3]];
  assign d_in_range = (d_addr_q[ADDR_W-1:IDX_W+3] == '0);

  mem_bridge_lane u_lane (
    .word        (d_word),
    .offset      (d_addr_q[2:0]),
    .size        (d_size_q),
    .is_unsigned (d_uns_q),
    .wdata       (d_wdata_q),
    .aligned     (lane_aligned),
    .load_val    (lane_load),
    .store_word  (lane_store)
  );

`ifdef MEM_BRIDGE_MMIO_EN
  localparam logic [ADDR_W-1:0] HALT_ADDR    = ADDR_W'(0) - ADDR_W'(HALT_OFS);
  localparam logic [ADDR_W-1:0] CONSOLE_ADDR = ADDR_W'(0) - ADDR_W'(CONSOLE_OFS);
  localparam logic [ADDR_W-1:0] PRINT_ADDR   = ADDR_W'(0) - ADDR_W'(PRINT_OFS);

  assign d_mmio = (d_addr_q == HALT_ADDR) || (d_addr_q == CONSOLE_ADDR) ||
                  (d_addr_q == PRINT_ADDR);

  always_ff @(posedge phi1 or negedge rst) begin
    if (!rst) begin
      halt          <= 1'b0;
      console_valid <= 1'b0;
      console_char  <= '0;
      print_valid   <= 1'b0;
      print_value   <= '0;
    end else begin
      console_valid <= 1'b0;
      print_valid   <= 1'b0;
      if (d_resp && d_store_q) begin
        if (d_addr_q == HALT_ADDR) halt <= 1'b1;
        if (d_addr_q == CONSOLE_ADDR) begin
          console_valid <= 1'b1;
          console_char  <= d_wdata_q[7:0];
        end
        if (d_addr_q == PRINT_ADDR) begin
          print_valid <= 1'b1;
          print_value <= d_wdata_q;
        end
      end
    end
  end
`else
  assign d_mmio        = 1'b0;
  assign halt          = 1'b0;
  assign console_valid = 1'b0;
  assign console_char  = '0;
  assign print_valid   = 1'b0;
  assign print_value   = '0;
`endif

  // MMIO addresses lie outside the memory region but are not errors.
  assign d_bad = !d_mmio && !(d_in_range && lane_aligned);

  always_ff @(posedge phi1 or negedge rst) begin
    if (!rst) begin
      d_state              <= ST_IDLE;
      d_cnt                <= '0;
      d_addr_q             <= '0;
      d_size_q             <= SZ_BYTE;
      d_uns_q              <= 1'b0;
      d_store_q            <= 1'b0;
      d_wdata_q            <= '0;
      input_data           <= '0;
      input_data_valid     <= 1'b0;
      output_data_complete <= 1'b0;
    end else begin
      d_state <= d_state_nx;
      d_cnt   <= d_cnt_nx;
      if (d_latch) begin
        d_addr_q  <= data_address;
        d_size_q  <= size_e'(data_size);
        d_uns_q   <= input_data_unsigned;
        d_store_q <= output_data_request;
        d_wdata_q <= output_data;
      end
      input_data_valid     <= d_resp && !d_store_q;
      output_data_complete <= d_resp && d_store_q;
      if (d_resp && !d_store_q)
        input_data <= (d_bad || d_mmio) ? 64'd0 : lane_load;
    end
  end

  // Fetch reads in the same cycle see the pre-store contents.
  always_ff @(posedge phi1) begin
    if (d_resp && d_store_q && !d_bad && !d_mmio)
      mem[d_addr_q[IDX_W+2:3]] <= lane_store;
  end

  always_ff @(posedge phi1 or negedge rst) begin
    if (!rst) err <= 1'b0;
    else if (d_conflict || (d_resp && d_bad) ||
             ((i_state == ST_RESP) && !i_in_range))
      err <= 1'b1;
  end

  // Fetch words are 32-bit; the low address bits carry no information.
  logic unused_fetch_bits;
  assign unused_fetch_bits = &{1'b0, i_addr_q[1:0]};

endmodule

// File: tb/tb_mem_bridge.sv
module tb_mem_bridge;

  localparam int AW    = 56;
  localparam int DEPTH = 4096;
  localparam int ILAT  = 0;
  localparam int DLAT  = 3;

  logic          phi1 = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] instruction_address = '0;
  logic          input_instruction_request = 1'b0;
  logic [31:0]   input_instruction;
  logic          input_instruction_valid;
  logic [AW-1:0] data_address = '0;
  logic [1:0]    data_size = '0;
  logic          input_data_unsigned = 1'b0;
  logic          input_data_request = 1'b0;
  logic [63:0]   input_data;
  logic          input_data_valid;
  logic [63:0]   output_data = '0;
  logic          output_data_request = 1'b0;
  logic          output_data_complete;
  logic          halt, console_valid, print_valid, err;
  logic [7:0]    console_char;
  logic [63:0]   print_value;

  always #5 phi1 = ~phi1;

  mem_bridge #(.ADDR_W(AW), .DEPTH_WORDS(DEPTH), .INSTR_LATENCY(ILAT),
               .DATA_LATENCY(DLAT)) dut (
    .phi1(phi1), .rst(rst),
    .instruction_address(instruction_address),
    .input_instruction_request(input_instruction_request),
    .input_instruction(input_instruction),
    .input_instruction_valid(input_instruction_valid),
    .data_address(data_address), .data_size(data_size),
    .input_data_unsigned(input_data_unsigned),
    .input_data_request(input_data_request),
    .input_data(input_data), .input_data_valid(input_data_valid),
    .output_data(output_data), .output_data_request(output_data_request),
    .output_data_complete(output_data_complete),
    .halt(halt), .console_valid(console_valid), .console_char(console_char),
    .print_valid(print_valid), .print_value(print_value), .err(err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Byte-addressed reference memory, little-endian.
  logic [7:0] mb [0:DEPTH*8-1];
  bit err_m = 0;

  typedef struct { bit is_store; logic [63:0] data; bit err; } dexp_t;
  dexp_t       exp_d[$];
  logic [31:0] exp_i[$];

  // Values seen by the monitor at the last data-port response.
  logic [63:0] last_rd;
  logic        last_cv, last_pv;
  logic [7:0]  last_cc;
  logic [63:0] last_pval;

  function automatic bit is_mmio(input logic [AW-1:0] a);
`ifdef MEM_BRIDGE_MMIO_EN
    return (a == 56'hFF_FFFF_FFFF_FFF8) || (a == 56'hFF_FFFF_FFFF_FFFC) ||
           (a == 56'hFF_FFFF_FFFF_FFF0);
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge phi1) begin
    if (input_data_valid || output_data_complete) begin
      if (exp_d.size() == 0) chk("unexpected data response", 64'd1, 64'd0);
      else begin
        dexp_t e;
        e = exp_d.pop_front();
        chk("data kind", {63'd0, output_data_complete}, {63'd0, e.is_store});
        if (!e.is_store) chk("load data", input_data, e.data);
        chk("data err", {63'd0, err}, {63'd0, e.err});
        last_rd   = input_data;
        last_cv   = console_valid;
        last_cc   = console_char;
        last_pv   = print_valid;
        last_pval = print_value;
      end
    end
    if (input_instruction_valid) begin
      if (exp_i.size() == 0) chk("unexpected fetch response", 64'd1, 64'd0);
      else chk("fetch data", {32'd0, input_instruction}, {32'd0, exp_i.pop_front()});
    end
  end

  task automatic data_txn(input bit st, input logic [AW-1:0] a, input logic [1:0] sz,
                          input bit uns, input logic [63:0] wd);
    int nb, n;
    bit bad, seen, mm;
    logic [63:0] rd;
    dexp_t e;
    nb = 1 << sz;
    mm = is_mmio(a);
    bad = !mm && ((a >= 56'(DEPTH*8)) || ((a % 56'(nb)) != 0));
    rd = 64'd0;
    if (!st && !bad && !mm) begin
      for (int i = 0; i < nb; i++) rd[8*i +: 8] = mb[int'(a) + i];
      if (!uns && nb < 8 && rd[8*nb-1]) rd = rd | (~64'd0 << (8*nb));
    end
    if (bad) err_m = 1;
    e.is_store = st; e.data = rd; e.err = err_m;
    exp_d.push_back(e);
    @(posedge phi1); #1;
    data_address = a; data_size = sz; input_data_unsigned = uns; output_data = wd;
    if (st) output_data_request = 1'b1; else input_data_request = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge phi1); #1; n++;
      if (st ? output_data_complete : input_data_valid) seen = 1;
    end
    input_data_request = 1'b0; output_data_request = 1'b0;
    chk("data latency", 64'(n), 64'(2 + DLAT));
    if (st && seen && !bad && !mm)
      for (int i = 0; i < nb; i++) mb[int'(a) + i] = wd[8*i +: 8];
    @(posedge phi1); #1;
    chk("single pulse", {62'd0, input_data_valid, output_data_complete}, 64'd0);
  endtask

  task automatic fetch_txn(input logic [AW-1:0] a);
    int n, base;
    bit seen;
    logic [31:0] v;
    base = int'(a) & ~3;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = mb[base + i];
    exp_i.push_back(v);
    @(posedge phi1); #1;
    instruction_address = a; input_instruction_request = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge phi1); #1; n++;
      if (input_instruction_valid) seen = 1;
    end
    input_instruction_request = 1'b0;
    chk("fetch latency", 64'(n), 64'(2 + ILAT));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    repeat (3) @(posedge phi1);
    @(negedge phi1);
    chk("reset valid", {61'd0, input_data_valid, output_data_complete,
                        input_instruction_valid}, 64'd0);
    chk("reset data", input_data, 64'd0);
    chk("reset instr", {32'd0, input_instruction}, 64'd0);
    chk("reset flags", {59'd0, halt, err, console_valid, print_valid, 1'b0}, 64'd0);
    @(posedge phi1); #1; rst = 1'b1;

    // Fill the low 1 KiB so every later load reads defined data.
    for (int a = 0; a < 1024; a += 8) data_txn(1, 56'(a), 2'd3, 0, {$urandom, $urandom});

    data_txn(1, 56'h100, 2'd3, 0, 64'h1122334455667788);
    data_txn(0, 56'h103, 2'd0, 0, 0);
    chk("byte 0x103", last_rd, 64'h55);
    data_txn(0, 56'h106, 2'd1, 0, 0);
    chk("half 0x106", last_rd, 64'h1122);

    data_txn(1, 56'h201, 2'd0, 0, 64'h80);
    data_txn(0, 56'h201, 2'd0, 0, 0);
    chk("signed byte 0x201", last_rd, 64'hFFFFFFFFFFFFFF80);
    data_txn(0, 56'h201, 2'd0, 1, 0);
    chk("unsigned byte 0x201", last_rd, 64'h80);
    data_txn(0, 56'h200, 2'd3, 0, 0);

    data_txn(0, 56'h102, 2'd2, 0, 0);
    chk("misaligned word", last_rd, 64'd0);
    chk("misaligned err", {63'd0, err}, 64'd1);

    // Reset during WAIT of a misaligned load.
    @(posedge phi1); #1;
    data_address = 56'h102; data_size = 2'd2; input_data_request = 1'b1;
    @(posedge phi1); #1;
    rst = 1'b0; input_data_request = 1'b0; err_m = 0;
    pulses = 0;
    repeat (3) begin @(negedge phi1); if (input_data_valid) pulses++; end
    chk("err after reset", {63'd0, err}, 64'd0);
    @(posedge phi1); #1; rst = 1'b1;
    repeat (6) begin @(negedge phi1); if (input_data_valid) pulses++; end
    chk("no valid across reset", 64'(pulses), 64'd0);
    chk("err stays clear", {63'd0, err}, 64'd0);

    // Concurrent fetch and store to the same word.
    fork
      fetch_txn(56'h300);
      data_txn(1, 56'h300, 2'd3, 0, 64'hCAFEF00D_DEADBEEF);
    join
    fetch_txn(56'h300);
    fetch_txn(56'h304);

    // Load and store together: store wins, err set, load ignored.
    begin
      dexp_t e;
      int n;
      err_m = 1;
      e.is_store = 1; e.data = 0; e.err = 1;
      exp_d.push_back(e);
      @(posedge phi1); #1;
      data_address = 56'h308; data_size = 2'd3; output_data = 64'h0123456789ABCDEF;
      output_data_request = 1'b1; input_data_request = 1'b1;
      n = 0;
      while (!output_data_complete && n < 40) begin @(posedge phi1); #1; n++; end
      output_data_request = 1'b0; input_data_request = 1'b0;
      chk("conflict latency", 64'(n), 64'(2 + DLAT));
      for (int i = 0; i < 8; i++) mb[32'h308 + i] = 8'(64'h0123456789ABCDEF >> (8*i));
      repeat (8) @(posedge phi1);
      data_txn(0, 56'h308, 2'd3, 0, 0);
    end

`ifdef MEM_BRIDGE_MMIO_EN
    data_txn(1, 56'hFF_FFFF_FFFF_FFFC, 2'd3, 0, 64'h41);
    chk("console pulse", {55'd0, last_cv, last_cc}, {55'd0, 1'b1, 8'h41});
    data_txn(1, 56'hFF_FFFF_FFFF_FFF0, 2'd3, 0, 64'hFFFFFFFFFFFFFFFB);
    chk("print pulse", {63'd0, last_pv}, 64'd1);
    chk("print value", last_pval, 64'hFFFFFFFFFFFFFFFB);
    data_txn(1, 56'hFF_FFFF_FFFF_FFF8, 2'd3, 0, 64'h1);
    repeat (3) @(posedge phi1);
    #1 chk("halt sticky", {63'd0, halt}, 64'd1);
`else
    data_txn(1, 56'hFF_FFFF_FFFF_FFF8, 2'd3, 0, 64'h1);
    chk("halt tied low", {63'd0, halt}, 64'd0);
    data_txn(1, 56'hFF_FFFF_FFFF_FFFC, 2'd3, 0, 64'h41);
    chk("console tied low", {55'd0, last_cv, last_cc}, 64'd0);
`endif

    // Randomized mix against the byte model.
    for (int t = 0; t < 160; t++) begin
      int r, nb;
      logic [1:0] sz;
      logic [AW-1:0] a;
      r  = $urandom_range(0, 9);
      sz = 2'($urandom_range(0, 3));
      nb = 1 << sz;
      a  = 56'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) a = a & ~56'(nb - 1);
      if (r < 2) fetch_txn(a);
      else if (r == 9) data_txn(1'($urandom_range(0, 1)), 56'(32768 + $urandom_range(0, 4095)),
                                sz, 0, {$urandom, $urandom});
      else data_txn(r < 5, a, sz, 1'($urandom_range(0, 1)), {$urandom, $urandom});
    end

    repeat (5) @(posedge phi1);
    chk("data queue drained", 64'(exp_d.size()), 64'd0);
    chk("fetch queue drained", 64'(exp_i.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
